tta16_io_bridge: RTL and testbench

Wishbone IO-bus slave that sits directly downstream of the tta16_tile io_* master port. It decodes io_adr[20:18] into regions and forwards cycles to the external CRTC, SPROM and DMA slaves. It implements the LED register and the cache-flush pulse locally, and terminates unmapped or hung cycles with an error. Classic atomic Wishbone only; io_cti/io_bte are ignored.

---
 rtl/tta16_io_bridge.sv | 194 +++++++++++++++++++
 tb/tb_tta16_io_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tta16_io_bridge.sv
// Wishbone IO-bus slave for the tta16 tile: decodes io_adr_i[20:18], forwards cycles to the
// CRTC/SPROM/DMA slaves, and serves the LED register and cache-flush pulse locally.
module tta16_io_bridge #(
    parameter int unsigned LEDS_WIDTH   = 8,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                  wb_clk,
    input  logic                  reset,
    input  logic                  io_cyc_i,
    input  logic                  io_stb_i,
    input  logic                  io_we_i,
    input  logic [20:0]           io_adr_i,
    input  logic [1:0]            io_sel_i,
    input  logic [15:0]           io_dat_i,
    output logic                  io_ack_o,
    output logic                  io_err_o,
    output logic                  io_rty_o,
    output logic [15:0]           io_dat_o,
    output logic                  crtc_stb_o,
    output logic                  sprom_stb_o,
    output logic                  dma_stb_o,
    output logic                  sub_we_o,
    output logic [17:0]           sub_adr_o,
    output logic [1:0]            sub_sel_o,
    output logic [15:0]           sub_dat_o,
    input  logic                  crtc_ack_i,
    input  logic                  sprom_ack_i,
    input  logic                  dma_ack_i,
    input  logic                  dma_err_i,
    input  logic [15:0]           crtc_dat_i,
    input  logic [15:0]           sprom_dat_i,
    input  logic [15:0]           dma_dat_i,
    output logic [LEDS_WIDTH-1:0] leds_o,
    output logic                  cache_rst_o
);

    typedef enum logic [1:0] {StIdle, StFwd, StResp, StHold} state_e;

    localparam logic [2:0] RegCrtc  = 3'b000;
    localparam logic [2:0] RegSprom = 3'b001;
    localparam logic [2:0] RegLeds  = 3'b010;
    localparam logic [2:0] RegDma   = 3'b100;
    localparam logic [2:0] RegFlush = 3'b110;

    state_e                r_state;
    logic [2:0]            r_fwd;      // one-hot {dma, sprom, crtc} of the slave being forwarded to
    logic                  r_we;
    logic [7:0]            r_cnt;
    logic [3:0]            r_flush_cnt;
    logic                  r_ack;
    logic                  r_err;
    logic [15:0]           r_dat;
    logic [LEDS_WIDTH-1:0] r_leds;

    logic                  w_req;
    logic [2:0]            w_region;
    logic [2:0]            w_dec_fwd;
    logic                  w_is_leds;
    logic                  w_is_flush;
    logic [2:0]            w_stb;
    logic                  w_slv_ack;
    logic                  w_slv_err;
    logic [15:0]           w_slv_dat;
    logic                  w_fwd_live;
    logic                  w_fwd_ack;
    logic                  w_fwd_err;
    logic [LEDS_WIDTH-1:0] w_leds_next;

    // Reset masks the request so no strobe or pass-through response escapes during reset.
    assign w_req      = io_cyc_i & io_stb_i & ~reset;
    assign w_region   = io_adr_i[20:18];
    assign w_dec_fwd  = {w_region == RegDma, w_region == RegSprom, w_region == RegCrtc};
    assign w_is_leds  = (w_region == RegLeds);
    assign w_is_flush = (w_region == RegFlush);

    always_comb begin
        w_stb = 3'b000;
        if (w_req && r_state == StIdle) begin
            w_stb = w_dec_fwd;
        end else if (w_req && r_state == StFwd) begin
            w_stb = r_fwd;
        end
    end

    assign w_slv_ack = |(r_fwd & {dma_ack_i, sprom_ack_i, crtc_ack_i});
    assign w_slv_err = r_fwd[2] & dma_err_i;
    assign w_slv_dat = ({16{r_fwd[0]}} & crtc_dat_i)
                     | ({16{r_fwd[1]}} & sprom_dat_i)
                     | ({16{r_fwd[2]}} & dma_dat_i);

    assign w_fwd_live = w_req & (r_state == StFwd);
    assign w_fwd_ack  = w_fwd_live & w_slv_ack;
    assign w_fwd_err  = w_fwd_live & w_slv_err;

    always_comb begin
        w_leds_next = r_leds;
        for (int i = 0; i < int'(LEDS_WIDTH); i++) begin
            if (io_sel_i[i / 8]) begin
                w_leds_next[i] = io_dat_i[i];
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_fwd       <= 3'b000;
            r_we        <= 1'b0;
            r_cnt       <= 8'd0;
            r_flush_cnt <= 4'd0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= 16'h0000;
            r_leds      <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 16'h0000;
            if (r_flush_cnt != 4'd0) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_we <= io_we_i;
                        if (|w_dec_fwd) begin
                            r_fwd   <= w_dec_fwd;
                            r_cnt   <= 8'd0;
                            r_state <= StFwd;
                        end else begin
                            r_state <= StResp;
                            if (w_is_leds) begin
                                r_ack <= 1'b1;
                                if (io_we_i) begin
                                    r_leds <= w_leds_next;
                                end else begin
                                    r_dat <= 16'(r_leds);
                                end
                            end else if (w_is_flush) begin
                                r_ack <= 1'b1;
                                if (io_we_i) begin
                                    r_flush_cnt <= 4'(FLUSH_CYCLES);
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                StFwd: begin
                    if (!w_req) begin
                        r_fwd   <= 3'b000;
                        r_cnt   <= 8'd0;
                        r_state <= StIdle;
                    end else if (w_slv_ack || w_slv_err) begin
                        r_fwd   <= 3'b000;
                        r_cnt   <= 8'd0;
                        r_state <= StHold;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        // Slave never answered: terminate with a one-cycle registered error.
                        r_fwd   <= 3'b000;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b1;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp:  r_state <= StHold;
                StHold:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign crtc_stb_o  = w_stb[0];
    assign sprom_stb_o = w_stb[1];
    assign dma_stb_o   = w_stb[2];

    assign io_ack_o = r_ack | w_fwd_ack;
    assign io_err_o = r_err | w_fwd_err;
    assign io_rty_o = 1'b0;
    assign io_dat_o = r_dat | ((w_fwd_ack && !r_we) ? w_slv_dat : 16'h0000);

    assign sub_we_o  = io_we_i;
    assign sub_adr_o = io_adr_i[17:0];
    assign sub_sel_o = io_sel_i;
    assign sub_dat_o = io_dat_i;

    assign leds_o      = r_leds;
    assign cache_rst_o = (r_flush_cnt != 4'd0);

endmodule

// File: tb/tb_tta16_io_bridge.sv
// Randomized self-checking bench for tta16_io_bridge: transaction-level timeline model with a
// per-cycle compare process, plus literal expectations for the directed scenarios.
module tb_tta16_io_bridge;

    localparam int unsigned LW    = 8;
    localparam int unsigned FLUSH = 4;
    localparam int unsigned TMO   = 15;
    localparam logic [15:0] LedMask = 16'((32'd1 << LW) - 1);

    logic          wb_clk = 1'b0;
    logic          reset;
    logic          io_cyc_i, io_stb_i, io_we_i;
    logic [20:0]   io_adr_i;
    logic [1:0]    io_sel_i;
    logic [15:0]   io_dat_i;
    logic          io_ack_o, io_err_o, io_rty_o;
    logic [15:0]   io_dat_o;
    logic          crtc_stb_o, sprom_stb_o, dma_stb_o;
    logic          sub_we_o;
    logic [17:0]   sub_adr_o;
    logic [1:0]    sub_sel_o;
    logic [15:0]   sub_dat_o;
    logic          crtc_ack_i, sprom_ack_i, dma_ack_i, dma_err_i;
    logic [15:0]   crtc_dat_i, sprom_dat_i, dma_dat_i;
    logic [LW-1:0] leds_o;
    logic          cache_rst_o;

    tta16_io_bridge #(
        .LEDS_WIDTH  (LW),
        .FLUSH_CYCLES(FLUSH),
        .TIMEOUT     (TMO)
    ) dut (
        .wb_clk     (wb_clk),
        .reset      (reset),
        .io_cyc_i   (io_cyc_i),
        .io_stb_i   (io_stb_i),
        .io_we_i    (io_we_i),
        .io_adr_i   (io_adr_i),
        .io_sel_i   (io_sel_i),
        .io_dat_i   (io_dat_i),
        .io_ack_o   (io_ack_o),
        .io_err_o   (io_err_o),
        .io_rty_o   (io_rty_o),
        .io_dat_o   (io_dat_o),
        .crtc_stb_o (crtc_stb_o),
        .sprom_stb_o(sprom_stb_o),
        .dma_stb_o  (dma_stb_o),
        .sub_we_o   (sub_we_o),
        .sub_adr_o  (sub_adr_o),
        .sub_sel_o  (sub_sel_o),
        .sub_dat_o  (sub_dat_o),
        .crtc_ack_i (crtc_ack_i),
        .sprom_ack_i(sprom_ack_i),
        .dma_ack_i  (dma_ack_i),
        .dma_err_i  (dma_err_i),
        .crtc_dat_i (crtc_dat_i),
        .sprom_dat_i(sprom_dat_i),
        .dma_dat_i  (dma_dat_i),
        .leds_o     (leds_o),
        .cache_rst_o(cache_rst_o)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc_n = 0;
    always @(posedge wb_clk) cyc_n <= cyc_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: expected outputs for the current cycle, LED contents, flush pulse end cycle.
    logic        chk_en = 1'b0;
    logic [2:0]  e_stb;
    logic        e_ack, e_err;
    logic [15:0] e_dat;
    logic [15:0] m_leds = 16'h0000;
    int          m_flush_end = 0;

    // Snapshots gathered while stepping, used by literal checks.
    int          n_stb, n_rst, n_resp;
    int          s_start, s_resp_cyc, s_rst_first;
    logic [15:0] s_dat, s_leds;
    logic        s_ack, s_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    always @(negedge wb_clk) begin
        if (chk_en && !reset) begin
            check("crtc_stb", 32'(crtc_stb_o), 32'(e_stb[0]));
            check("sprom_stb", 32'(sprom_stb_o), 32'(e_stb[1]));
            check("dma_stb", 32'(dma_stb_o), 32'(e_stb[2]));
            check("io_ack", 32'(io_ack_o), 32'(e_ack));
            check("io_err", 32'(io_err_o), 32'(e_err));
            check("io_rty", 32'(io_rty_o), 32'd0);
            check("io_dat", 32'(io_dat_o), 32'(e_dat));
            check("leds", 32'(leds_o), 32'(m_leds));
            check("cache_rst", 32'(cache_rst_o), 32'(cyc_n < m_flush_end));
            check("sub_we", 32'(sub_we_o), 32'(io_we_i));
            check("sub_adr", 32'(sub_adr_o), 32'(io_adr_i[17:0]));
            check("sub_sel", 32'(sub_sel_o), 32'(io_sel_i));
            check("sub_dat", 32'(sub_dat_o), 32'(io_dat_i));
        end
    end

    task automatic tick();
        @(negedge wb_clk);
        if (!reset) begin
            if (crtc_stb_o || sprom_stb_o || dma_stb_o) n_stb++;
            if (io_ack_o || io_err_o) begin
                n_resp++;
                s_resp_cyc = cyc_n;
                s_dat      = io_dat_o;
                s_ack      = io_ack_o;
                s_err      = io_err_o;
            end
            if (cache_rst_o) begin
                if (n_rst == 0) s_rst_first = cyc_n;
                n_rst++;
            end
            s_leds = 16'(leds_o);
        end
        @(posedge wb_clk);
        #1;
    endtask

    task automatic exp_zero();
        e_stb = 3'b000;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = 16'h0000;
    endtask

    // Unselected slaves chatter at random; the selected one stays quiet unless told to answer.
    task automatic noise(input int slot);
        crtc_ack_i  = 1'($urandom);
        sprom_ack_i = 1'($urandom);
        dma_ack_i   = 1'($urandom);
        dma_err_i   = 1'($urandom);
        crtc_dat_i  = 16'($urandom);
        sprom_dat_i = 16'($urandom);
        dma_dat_i   = 16'($urandom);
        if (slot == 0) crtc_ack_i = 1'b0;
        if (slot == 1) sprom_ack_i = 1'b0;
        if (slot == 2) begin
            dma_ack_i = 1'b0;
            dma_err_i = 1'b0;
        end
    endtask

    task automatic master_idle();
        io_cyc_i = 1'b0;
        io_stb_i = 1'b0;
        io_we_i  = 1'($urandom);
        io_adr_i = 21'($urandom);
        io_sel_i = 2'($urandom);
        io_dat_i = 16'($urandom);
    endtask

    task automatic master_req(input logic [2:0] code, input logic [17:0] lo, input logic we,
                              input logic [1:0] sl, input logic [15:0] wd);
        io_cyc_i = 1'b1;
        io_stb_i = 1'b1;
        io_we_i  = we;
        io_adr_i = {code, lo};
        io_sel_i = sl;
        io_dat_i = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            master_idle();
            noise(-1);
            exp_zero();
            tick();
        end
    endtask

    task automatic model_reset();
        m_leds      = 16'h0000;
        m_flush_end = 0;
    endtask

    // Forwarded access: strobe from the request cycle until the slave answers at cycle `lat`
    // (1..TMO), or an error one cycle after TMO forwarded cycles when it never answers.
    task automatic fwd_txn(input logic [2:0] code, input logic we, input int lat,
                           input logic use_err, input logic [15:0] rd, input int abort_at,
                           input int rst_at);
        int          slot = (code == 3'b000) ? 0 : (code == 3'b001) ? 1 : 2;
        int          resp = (lat >= 1 && lat <= int'(TMO)) ? lat : 0;
        logic [17:0] lo   = 18'($urandom);
        logic [15:0] wd   = 16'($urandom);
        logic [1:0]  sl   = 2'($urandom);
        s_start = cyc_n;
        for (int k = 0; k < 64; k++) begin
            noise(slot);
            exp_zero();
            if (rst_at != 0 && k == rst_at) begin
                master_idle();
                reset = 1'b1;
                tick();
                reset = 1'b0;
                model_reset();
                return;
            end
            if (abort_at != 0 && k == abort_at) begin
                master_idle();
                tick();
                return;
            end
            master_req(code, lo, we, sl, wd);
            if (resp == 0 && k == int'(TMO) + 1) begin
                e_err = 1'b1;
                tick();
                break;
            end
            e_stb[slot] = 1'b1;
            if (resp != 0 && k == resp) begin
                if (slot == 0) begin crtc_ack_i = 1'b1; crtc_dat_i = rd; end
                if (slot == 1) begin sprom_ack_i = 1'b1; sprom_dat_i = rd; end
                if (slot == 2) begin
                    dma_dat_i = rd;
                    if (use_err) dma_err_i = 1'b1;
                    else dma_ack_i = 1'b1;
                end
                if (use_err) begin
                    e_err = 1'b1;
                end else begin
                    e_ack = 1'b1;
                    e_dat = we ? 16'h0000 : rd;
                end
                tick();
                break;
            end
            tick();
        end
        master_idle();
        noise(-1);
        exp_zero();
        tick();
    endtask

    // Local or unmapped access: registered response in the cycle after the request.
    task automatic local_txn(input logic [2:0] code, input logic we, input logic [1:0] sl,
                             input logic [15:0] wd);
        logic [17:0] lo = 18'($urandom);
        logic [15:0] nl;
        s_start = cyc_n;
        noise(-1);
        exp_zero();
        master_req(code, lo, we, sl, wd);
        tick();
        noise(-1);
        exp_zero();
        if (code == 3'b010) begin
            e_ack = 1'b1;
            if (we) begin
                nl = m_leds;
                if (sl[0]) nl[7:0] = wd[7:0];
                if (sl[1]) nl[15:8] = wd[15:8];
                m_leds = nl & LedMask;
            end else begin
                e_dat = m_leds;
            end
        end else if (code == 3'b110) begin
            e_ack = 1'b1;
            if (we) m_flush_end = cyc_n + int'(FLUSH);
        end else begin
            e_err = 1'b1;
        end
        tick();
        master_idle();
        noise(-1);
        exp_zero();
        tick();
    endtask

    initial begin
        int resp0;
        n_stb = 0; n_rst = 0; n_resp = 0;
        s_start = 0; s_resp_cyc = 0; s_rst_first = 0;
        s_dat = '0; s_leds = '0; s_ack = 1'b0; s_err = 1'b0;
        reset = 1'b1;
        master_idle();
        noise(-1);
        exp_zero();
        repeat (3) @(posedge wb_clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        idle(2);
        check("reset_leds", 32'(s_leds), 32'h0);
        check("reset_no_resp", 32'(n_resp), 32'd0);

        local_txn(3'b010, 1'b1, 2'b01, 16'h00A5);
        check("leds_ack_latency", 32'(s_resp_cyc - s_start), 32'd1);
        check("leds_write", 32'(s_leds), 32'h00A5);
        local_txn(3'b010, 1'b0, 2'b11, 16'h0000);
        check("leds_readback", 32'(s_dat), 32'h00A5);
        local_txn(3'b010, 1'b1, 2'b10, 16'hFF00);
        check("leds_high_sel", 32'(s_leds), 32'h00A5);

        n_rst = 0;
        local_txn(3'b110, 1'b1, 2'b11, 16'h1111);
        idle(6);
        check("flush_len", 32'(n_rst), 32'd4);
        check("flush_align", 32'(s_rst_first), 32'(s_resp_cyc));
        n_rst = 0;
        local_txn(3'b110, 1'b0, 2'b11, 16'h0000);
        idle(6);
        check("flush_read_ack", 32'(s_ack), 32'd1);
        check("flush_read_dat", 32'(s_dat), 32'h0);
        check("flush_read_nopulse", 32'(n_rst), 32'd0);

        n_stb = 0;
        fwd_txn(3'b000, 1'b0, 2, 1'b0, 16'h1234, 0, 0);
        check("crtc_stb_cycles", 32'(n_stb), 32'd3);
        check("crtc_read_dat", 32'(s_dat), 32'h1234);

        n_stb = 0;
        fwd_txn(3'b001, 1'b0, 0, 1'b0, 16'h0000, 0, 0);
        check("sprom_timeout_at", 32'(s_resp_cyc - s_start), 32'd16);
        check("sprom_timeout_err", 32'(s_err), 32'd1);
        check("sprom_stb_cycles", 32'(n_stb), 32'd16);
        local_txn(3'b010, 1'b0, 2'b01, 16'h0000);
        check("after_timeout_ack", 32'(s_ack), 32'd1);

        n_stb = 0;
        local_txn(3'b101, 1'b0, 2'b11, 16'h0000);
        check("unmapped_101_err", 32'(s_err), 32'd1);
        local_txn(3'b111, 1'b1, 2'b11, 16'hBEEF);
        check("unmapped_111_err", 32'(s_err), 32'd1);
        check("unmapped_no_stb", 32'(n_stb), 32'd0);
        fwd_txn(3'b100, 1'b0, 3, 1'b1, 16'h5A5A, 0, 0);
        check("dma_err_pass", 32'(s_err), 32'd1);

        fwd_txn(3'b100, 1'b0, 0, 1'b0, 16'h0000, 0, 5);
        resp0 = n_resp;
        idle(20);
        check("dma_reset_no_ack", 32'(n_resp), 32'(resp0));
        check("dma_reset_leds", 32'(s_leds), 32'h0);

        local_txn(3'b010, 1'b1, 2'b01, 16'h003C);
        local_txn(3'b110, 1'b1, 2'b01, 16'h0000);
        master_idle();
        noise(-1);
        exp_zero();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_rst = 0;
        idle(5);
        check("flush_reset_cut", 32'(n_rst), 32'd0);
        check("flush_reset_leds", 32'(s_leds), 32'h0);

        for (int t = 0; t < 150; t++) begin
            logic [2:0] code = 3'($urandom);
            if (code == 3'b000 || code == 3'b001 || code == 3'b100) begin
                int lat   = ($urandom_range(0, 19) < 2) ? 0 : int'($urandom_range(1, 6));
                int abort = 0;
                if ($urandom_range(0, 7) == 0) begin
                    if (lat == 0) abort = int'($urandom_range(1, TMO));
                    else if (lat > 1) abort = int'($urandom_range(1, lat - 1));
                end
                fwd_txn(code, 1'($urandom), lat, (code == 3'b100) && ($urandom_range(0, 3) == 0),
                        16'($urandom), abort, 0);
            end else begin
                local_txn(code, 1'($urandom), 2'($urandom), 16'($urandom));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
